// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// word size and the default reset PC.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = ~(32'(WORD_BYTES) - 32'd1);

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack memory
// port and drives the IF/ID register, with stall, redirect and a one-deep hold buffer.
//
// state | meaning
// IDLE  | first cycle out of reset, no request yet
// FETCH | request outstanding at PC
// HOLD  | instruction captured during a stall, waiting for ID
// DROP  | redirected with a request in flight; waiting to swallow its ack
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  input  logic        IMem_Ack,
  input  logic [31:0] IMem_Data,
  output logic [31:0] Instruction_out,
  output logic [31:0] PC_out,
  output logic        Valid_out
);

  fetch_state_t state, state_next;

  logic [31:0] pc, pc_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic [31:0] hold_instr, hold_instr_next;
  logic [31:0] hold_pc, hold_pc_next;
  logic [31:0] instr_next, pc_out_next;
  logic        valid_next;

  logic [31:0] pc_inc;
  logic [31:0] target_pc;

  assign pc_inc    = pc + 32'(WORD_BYTES);
  assign target_pc = Redirect_PC & WORD_MASK;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state           <= IDLE;
      pc              <= RESET_PC;
      drop_addr       <= RESET_PC;
      hold_instr      <= 32'd0;
      hold_pc         <= 32'd0;
      Instruction_out <= 32'd0;
      PC_out          <= 32'd0;
      Valid_out       <= 1'b0;
    end else begin
      state           <= state_next;
      pc              <= pc_next;
      drop_addr       <= drop_addr_next;
      hold_instr      <= hold_instr_next;
      hold_pc         <= hold_pc_next;
      Instruction_out <= instr_next;
      PC_out          <= pc_out_next;
      Valid_out       <= valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    drop_addr_next  = drop_addr;
    hold_instr_next = hold_instr;
    hold_pc_next    = hold_pc;
    instr_next      = Instruction_out;
    pc_out_next     = PC_out;
    valid_next      = Valid_out;
    IMem_Req        = 1'b0;
    IMem_Addr       = pc;

    unique case (state)
      IDLE: begin
        state_next = FETCH;
        if (Redirect) begin
          pc_next    = target_pc;
          valid_next = 1'b0;
        end
      end

      FETCH: begin
        IMem_Req = 1'b1;
        if (Redirect) begin
          valid_next = 1'b0;
          pc_next    = target_pc;
          if (!IMem_Ack) begin
            state_next     = DROP;
            drop_addr_next = pc;
          end
        end else if (IMem_Ack) begin
          pc_next = pc_inc;
          if (Stall) begin
            hold_instr_next = IMem_Data;
            hold_pc_next    = pc_inc;
            state_next      = HOLD;
          end else begin
            instr_next  = IMem_Data;
            pc_out_next = pc_inc;
            valid_next  = 1'b1;
          end
        end else if (!Stall) begin
          valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (Redirect) begin
          valid_next = 1'b0;
          pc_next    = target_pc;
          state_next = FETCH;
        end else if (!Stall) begin
          instr_next  = hold_instr;
          pc_out_next = hold_pc;
          valid_next  = 1'b1;
          state_next  = FETCH;
        end
      end

      DROP: begin
        IMem_Req  = 1'b1;
        IMem_Addr = drop_addr;
        if (Redirect) begin
          valid_next = 1'b0;
          pc_next    = target_pc;
        end
        // The orphaned ack retires the old request even if a new redirect lands
        // the same cycle; waiting for another ack here would never end.
        if (IMem_Ack) begin
          state_next = FETCH;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
